demux_stream: RTL and testbench

- Registered 1-to-2 stream demultiplexer with valid/ready handshakes. It is the routing counterpart of the 2:1 datapath mux.
- One input stream carries data plus a per-beat select bit. Each beat is steered to output port a (sel=0) or port b (sel=1).
- Each output owns a one-entry register slice, so a stalled sink never corrupts the other path.
- Sits between a single producer, such as the K2 datapath result bus, and two independent consumers.

---
 rtl/demux_stream_if.sv | 26 ++
 rtl/demux_stream.sv | 93 +++++++++
 tb/tb_demux_stream.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/demux_stream_if.sv
// demux_stream_if: handshake bundle for the 1-to-2 stream demultiplexer.
// master = producer plus both sinks (bench side); slave = the demux itself.
interface demux_stream_if #(
    parameter int width = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [width-1:0] in_data;
    logic             in_sel;
    logic             a_valid;
    logic             a_ready;
    logic [width-1:0] a_data;
    logic             b_valid;
    logic             b_ready;
    logic [width-1:0] b_data;

    modport master (
        output in_valid, in_data, in_sel, a_ready, b_ready,
        input  in_ready, a_valid, a_data, b_valid, b_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, a_ready, b_ready,
        output in_ready, a_valid, a_data, b_valid, b_data
    );
endinterface

// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-2 stream demultiplexer. Each beat is steered
// by in_sel to port a (0) or port b (1); every output owns a one-entry slot,
// so a stalled sink only blocks beats aimed at it.
// Optional build macro DEMUX_STREAM_COUNT_EN adds saturating per-port beat
// counters (a_count, b_count) with a synchronous clear (cnt_clr).
module demux_stream #(
    parameter int width = 8
) (
    input  logic        clk,
    input  logic        rst,
`ifdef DEMUX_STREAM_COUNT_EN
    input  logic        cnt_clr,
    output logic [15:0] a_count,
    output logic [15:0] b_count,
`endif
    demux_stream_if.slave s
);

    logic             a_vld_p1;
    logic [width-1:0] a_data_p1;
    logic             b_vld_p1;
    logic [width-1:0] b_data_p1;

    logic in_ready;
    logic in_fire;
    logic a_fire;
    logic b_fire;
    logic a_load;
    logic b_load;

    // The selected slot can take a beat when it is empty or draining now;
    // in_valid is deliberately not involved, so no loop through the producer.
    assign in_ready = s.in_sel ? (~b_vld_p1 | s.b_ready)
                               : (~a_vld_p1 | s.a_ready);
    assign in_fire  = s.in_valid & in_ready;
    assign a_load   = in_fire & ~s.in_sel;
    assign b_load   = in_fire &  s.in_sel;
    assign a_fire   = a_vld_p1 & s.a_ready;
    assign b_fire   = b_vld_p1 & s.b_ready;

    assign s.in_ready = in_ready;
    assign s.a_valid  = a_vld_p1;
    assign s.a_data   = a_data_p1;
    assign s.b_valid  = b_vld_p1;
    assign s.b_data   = b_data_p1;

    // ---- input -> slot a boundary: load wins over drain, stall holds ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_vld_p1  <= 1'b0;
            a_data_p1 <= '0;
        end else if (a_load) begin
            a_vld_p1  <= 1'b1;
            a_data_p1 <= s.in_data;
        end else if (a_fire) begin
            a_vld_p1  <= 1'b0;
        end
    end

    // ---- input -> slot b boundary: same policy, independent of slot a ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_vld_p1  <= 1'b0;
            b_data_p1 <= '0;
        end else if (b_load) begin
            b_vld_p1  <= 1'b1;
            b_data_p1 <= s.in_data;
        end else if (b_fire) begin
            b_vld_p1  <= 1'b0;
        end
    end

`ifdef DEMUX_STREAM_COUNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Per-port delivered-beat counters; clear beats a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_count <= '0;
            b_count <= '0;
        end else if (cnt_clr) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (a_fire) a_count <= sat_inc(a_count);
            if (b_fire) b_count <= sat_inc(b_count);
        end
    end
`endif

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: vector table plus scoreboard bench for demux_stream.
module tb_demux_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux_stream_if #(.width(8)) bus ();

`ifdef DEMUX_STREAM_COUNT_EN
    logic        cnt_clr = 1'b0;
    logic [15:0] a_count;
    logic [15:0] b_count;
`endif

    demux_stream #(.width(8)) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef DEMUX_STREAM_COUNT_EN
        .cnt_clr (cnt_clr),
        .a_count (a_count),
        .b_count (b_count),
`endif
        .s       (bus.slave)
    );

    int nvec = 0;
    int nerr = 0;
    int bfires = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    typedef struct {
        logic       v;
        logic       sel;
        logic [7:0] d;
        logic       ar;
        logic       br;
        logic       ir;
        logic       av;
        logic [7:0] ad;
        logic       bv;
        logic [7:0] bd;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, sample handshakes 1ns before posedge,
    // update the scoreboard, return at the following negedge.
    task automatic step(input logic v, input logic sel, input logic [7:0] d,
                        input logic ar, input logic br,
                        output logic ir_obs, output logic bfire_obs);
        logic [7:0] e;
        bus.in_valid = v;
        bus.in_sel   = sel;
        bus.in_data  = d;
        bus.a_ready  = ar;
        bus.b_ready  = br;
        #4;
        ir_obs    = bus.in_ready;
        bfire_obs = bus.b_valid & bus.b_ready;
        if (bus.a_valid && bus.a_ready) begin
            if (qa.size() == 0) chk("a_unexpected_beat", 32'd1, 32'd0);
            else begin
                e = qa.pop_front();
                chk("a_sb_data", {24'd0, bus.a_data}, {24'd0, e});
            end
        end
        if (bus.b_valid && bus.b_ready) begin
            bfires++;
            if (qb.size() == 0) chk("b_unexpected_beat", 32'd1, 32'd0);
            else begin
                e = qb.pop_front();
                chk("b_sb_data", {24'd0, bus.b_data}, {24'd0, e});
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            if (bus.in_sel) qb.push_back(bus.in_data);
            else            qa.push_back(bus.in_data);
        end
        @(negedge clk);
    endtask

    initial begin
        logic ir, bf;
        int   f0;

        //          v    sel  d      ar   br   ir   av   ad     bv   bd
        tbl[0]  = '{1'b1,1'b0,8'h01,1'b1,1'b1,1'b1,1'b1,8'h01,1'b0,8'h00};
        tbl[1]  = '{1'b1,1'b1,8'h02,1'b1,1'b1,1'b1,1'b0,8'h01,1'b1,8'h02};
        tbl[2]  = '{1'b1,1'b0,8'h03,1'b1,1'b1,1'b1,1'b1,8'h03,1'b0,8'h02};
        tbl[3]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,8'h03,1'b0,8'h02};
        tbl[4]  = '{1'b1,1'b0,8'hA0,1'b0,1'b1,1'b1,1'b1,8'hA0,1'b0,8'h02};
        tbl[5]  = '{1'b1,1'b1,8'hB0,1'b0,1'b1,1'b1,1'b1,8'hA0,1'b1,8'hB0};
        tbl[6]  = '{1'b1,1'b0,8'hA1,1'b0,1'b1,1'b0,1'b1,8'hA0,1'b0,8'hB0};
        tbl[7]  = '{1'b1,1'b0,8'hA1,1'b0,1'b1,1'b0,1'b1,8'hA0,1'b0,8'hB0};
        tbl[8]  = '{1'b1,1'b0,8'hA1,1'b1,1'b1,1'b1,1'b1,8'hA1,1'b0,8'hB0};
        tbl[9]  = '{1'b1,1'b1,8'h20,1'b0,1'b0,1'b1,1'b1,8'hA1,1'b1,8'h20};
        tbl[10] = '{1'b1,1'b0,8'h10,1'b1,1'b0,1'b1,1'b1,8'h10,1'b1,8'h20};
        tbl[11] = '{1'b1,1'b0,8'h30,1'b1,1'b1,1'b1,1'b1,8'h30,1'b0,8'h20};
        tbl[12] = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,8'h30,1'b0,8'h20};

        bus.in_valid = 1'b0;
        bus.in_sel   = 1'b0;
        bus.in_data  = 8'h00;
        bus.a_ready  = 1'b0;
        bus.b_ready  = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_a_valid", {31'd0, bus.a_valid}, 32'd0);
        chk("rst_b_valid", {31'd0, bus.b_valid}, 32'd0);
        chk("rst_a_data", {24'd0, bus.a_data}, 32'd0);
        chk("rst_b_data", {24'd0, bus.b_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Steering, backpressure isolation, simultaneous drain
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].ar, tbl[i].br, ir, bf);
            chk($sformatf("v%0d_in_ready", i), {31'd0, ir}, {31'd0, tbl[i].ir});
            chk($sformatf("v%0d_a_valid", i), {31'd0, bus.a_valid}, {31'd0, tbl[i].av});
            chk($sformatf("v%0d_a_data", i), {24'd0, bus.a_data}, {24'd0, tbl[i].ad});
            chk($sformatf("v%0d_b_valid", i), {31'd0, bus.b_valid}, {31'd0, tbl[i].bv});
            chk($sformatf("v%0d_b_data", i), {24'd0, bus.b_data}, {24'd0, tbl[i].bd});
        end

        // Reset mid-stream: slot a holds 5A, reset must clear it at once
        step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, ir, bf);
        chk("mid_a_loaded", {24'd0, bus.a_data}, 32'h5A);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_a_valid", {31'd0, bus.a_valid}, 32'd0);
        chk("mid_rst_a_data", {24'd0, bus.a_data}, 32'd0);
        qa.delete();
        qb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 8'h11, 1'b1, 1'b1, ir, bf);
        chk("post_rst_in_ready", {31'd0, ir}, 32'd1);
        chk("post_rst_a_valid", {31'd0, bus.a_valid}, 32'd1);
        chk("post_rst_a_data", {24'd0, bus.a_data}, 32'h11);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, ir, bf);

        // Full throughput to port b
        f0 = bfires;
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b1, i[7:0], 1'b1, 1'b1, ir, bf);
            chk("thr_in_ready", {31'd0, ir}, 32'd1);
            if (i > 0) chk("thr_no_bubble", {31'd0, bf}, 32'd1);
        end
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, ir, bf);
        chk("thr_b_fire_count", bfires - f0, 32'd256);
        chk("thr_b_empty", {31'd0, bus.b_valid}, 32'd0);

`ifdef DEMUX_STREAM_COUNT_EN
        // Saturating counter and clear priority
        for (int i = 0; i < 65537; i++) step(1'b1, 1'b0, i[7:0], 1'b1, 1'b1, ir, bf);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, ir, bf);
        chk("cnt_a_saturated", {16'd0, a_count}, 32'hFFFF);
        step(1'b1, 1'b0, 8'h77, 1'b1, 1'b1, ir, bf);
        cnt_clr = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, ir, bf);
        cnt_clr = 1'b0;
        chk("cnt_a_cleared", {16'd0, a_count}, 32'd0);
        chk("cnt_b_cleared", {16'd0, b_count}, 32'd0);
`endif

        chk("qa_drained", qa.size(), 32'd0);
        chk("qb_drained", qb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
